// File: rtl/gerador_sequencia.sv
// Serial bit-stream transmitter: accepts a word on start/ready, shifts len bits out MSB-first
// on x, optionally repeating the word with a one-cycle idle gap between copies.
module gerador_sequencia #(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter int   CNT_W      = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             ready,
    output logic             busy,
    output logic             bit_valid,
    output logic             x,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] rep;
    logic             bit_sel;

    // Out-of-range or zero length means "send the whole word".
    function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] l);
        if (l == '0 || l > WIDTH_L)
            return WIDTH_L;
        else
            return l;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            idx   <= '0;
            len_q <= '0;
            rep   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= data;
                        idx   <= len_eff(len) - ONE_L;
                        len_q <= len_eff(len);
                        rep   <= repeat_n;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx != '0)
                        idx <= idx - ONE_L;
                    else if (rep != '0)
                        state <= GAP;
                    else
                        state <= DONE;
                end
                GAP: begin
                    rep   <= rep - ONE_C;
                    idx   <= len_q - ONE_L;
                    state <= SHIFT;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Mux sr[idx] explicitly so the index width never has to match the word width.
    always_comb begin
        bit_sel = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (idx == LEN_W'(i))
                bit_sel = sr[i];
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == GAP);
    assign bit_valid = (state == SHIFT);
    assign done      = (state == DONE);
    assign x         = (state == SHIFT) ? bit_sel : IDLE_LEVEL;

endmodule

// File: tb/tb_gerador_sequencia.sv
// Bench for gerador_sequencia: per-cycle queue model of the expected output stream plus
// directed literal checks and a randomized phase.
module tb_gerador_sequencia;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [LEN_W-1:0] len = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic             ready, busy, bit_valid, x, done;

    int checks = 0;
    int errors = 0;

    gerador_sequencia #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .repeat_n(repeat_n), .ready(ready), .busy(busy), .bit_valid(bit_valid),
        .x(x), .done(done)
    );

    always #5 clk = ~clk;

    // Expected output vector per cycle: {ready, busy, bit_valid, done, x}
    localparam logic [4:0] E_IDLE = 5'b10001;
    localparam logic [4:0] E_GAP  = 5'b01001;
    localparam logic [4:0] E_DONE = 5'b00011;

    logic [4:0] q[$];

    task automatic push_transfer(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                                 input logic [CNT_W-1:0] r);
        int le;
        le = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = le - 1; b >= 0; b--)
                q.push_back({4'b0110, d[b]});
            if (k < int'(r))
                q.push_back(E_GAP);
        end
        q.push_back(E_DONE);
    endtask

    always @(posedge rst) q.delete();

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start)
                push_transfer(data, len, repeat_n);
        end else begin
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp_v, act_v;
        exp_v = (rst || q.size() == 0) ? E_IDLE : q[0];
        act_v = {ready, busy, bit_valid, done, x};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual {rdy,busy,bv,done,x}=%b required %b",
                     $time, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                        input logic [CNT_W-1:0] r);
        @(negedge clk);
        data = d; len = l; repeat_n = r; start = 1'b1;
    endtask

    // Samples n cycles after the accept edge; first sample is the first data bit.
    task automatic collect(input int n, output logic [31:0] xs, output logic [31:0] rd,
                           output int nb, output int nd, output int nv);
        xs = '0; rd = '0; nb = 0; nd = 0; nv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            #1;
            xs = {xs[30:0], x};
            rd = {rd[30:0], ready};
            nb += int'(busy);
            nd += int'(done);
            nv += int'(bit_valid);
        end
    endtask

    initial begin
        logic [31:0] xs, rd;
        int nb, nd, nv;

        // Reset held with start high: nothing may be accepted.
        start = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_x", 32'(x), 32'd1);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        send(8'b1001_0110, 4'd8, 4'd0);
        collect(10, xs, rd, nb, nd, nv);
        chk("word8_x", xs, 32'b10_0101_1011);
        chk("word8_bv", 32'(nv), 32'd8);
        chk("word8_done", 32'(nd), 32'd1);
        chk("word8_ready", rd, 32'b00_0000_0001);

        send(8'h0A, 4'd4, 4'd2);
        collect(16, xs, rd, nb, nd, nv);
        chk("rep_x", xs, 32'b1010_1101_0110_1011);
        chk("rep_busy", 32'(nb), 32'd14);
        chk("rep_done", 32'(nd), 32'd1);

        send(8'hC3, 4'd0, 4'd0);
        collect(8, xs, rd, nb, nd, nv);
        chk("len0_x", xs, 32'hC3);
        repeat (2) @(negedge clk);
        send(8'hC3, 4'd12, 4'd0);
        collect(8, xs, rd, nb, nd, nv);
        chk("len12_x", xs, 32'hC3);
        repeat (2) @(negedge clk);

        // Asynchronous abort during the third bit.
        send(8'hAA, 4'd8, 4'd0);
        collect(2, xs, rd, nb, nd, nv);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_x", 32'(x), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        collect(3, xs, rd, nb, nd, nv);
        chk("abort_nodone", 32'(nd), 32'd0);
        send(8'h5A, 4'd8, 4'd0);
        collect(10, xs, rd, nb, nd, nv);
        chk("after_abort_x", xs, 32'b01_0110_1011);

        // start held high, data changed mid-transfer.
        send(8'h00, 4'd8, 4'd0);
        xs = '0; rd = '0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) data = 8'hFF;
            #1;
            xs = {xs[30:0], x};
            rd = {rd[30:0], ready};
            nd += int'(done);
        end
        start = 1'b0;
        chk("hold_x", xs, 32'b0000_0000_1111_1111_1111);
        chk("hold_ready", rd, 32'b0000_0000_0100_0000_0001);
        chk("hold_done", 32'(nd), 32'd2);
        repeat (12) @(negedge clk);

        // Randomized traffic, occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            data     = WIDTH'($urandom);
            len      = LEN_W'($urandom);
            repeat_n = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        start = 1'b0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
